// File: rtl/sd_spi_responder_if.sv
// SPI link and block-RAM port bundle for the SD-card responder.
interface sd_spi_responder_if #(
    parameter int ADDR_W = 19
);
    logic              sclk;
    logic              cs;
    logic              mosi;
    logic              miso;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [7:0]        mem_rd_data;
    logic              mem_wr_en;
    logic [7:0]        mem_wr_data;
    logic              card_idle;
    logic              cmd_valid;
    logic [5:0]        cmd_idx;

    modport slave (
        input  sclk, cs, mosi, mem_rd_data,
        output miso, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data,
        output card_idle, cmd_valid, cmd_idx
    );

    modport master (
        output sclk, cs, mosi, mem_rd_data,
        input  miso, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data,
        input  card_idle, cmd_valid, cmd_idx
    );
endinterface

// File: rtl/sd_spi_responder.sv
// SPI-mode SD-card emulator: init, CMD17 block read, CMD24 block write against a byte RAM.
// Optional SD_RESP_CRC_CHECK_EN: verify command CRC7 and reject frames that fail it.
module sd_spi_responder #(
    parameter int NUM_BLOCKS   = 1024,
    parameter int ADDR_W       = 19,
    parameter int INIT_RETRIES = 2,
    parameter int NAC_BYTES    = 3,
    parameter int BUSY_BYTES   = 4
) (
    input  logic clk,
    input  logic rst_n,
    sd_spi_responder_if.slave bus
);
    localparam int BLK_W = ADDR_W - 9;
    localparam int ATT_W = $clog2(INIT_RETRIES + 2);

    typedef enum logic [3:0] {
        ST_HUNT, ST_CMD_RX, ST_NCR, ST_RESP,
        ST_RD_NAC, ST_RD_TOKEN, ST_RD_DATA, ST_RD_CRC,
        ST_WR_TOKEN, ST_WR_DATA, ST_WR_CRC, ST_WR_RESP, ST_WR_BUSY
    } state_t;

    typedef enum logic [1:0] {ACT_NONE, ACT_RD, ACT_WR} act_t;

    logic [2:0] sclk_s;
    logic [1:0] cs_s, mosi_s;
    logic       sclk_rise, sclk_fall, cs_hi, mosi_b;

    logic [2:0] bit_cnt;
    logic [6:0] rx_sr;
    logic [7:0] tx_sr, rx_byte, tx_nxt;
    logic       byte_done;

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [8:0] off, off_nxt, rd_off;
    logic       frame_done, cmd_shift, ext_shift, rd_req, wr_req;

    logic [37:0]      cmd_sr;
    logic [7:0]       r1_q;
    logic [31:0]      ext_q;
    logic             has_ext_q;
    act_t             act_q;
    logic [BLK_W-1:0] blk_q;
    logic             card_idle_q, app_q;
    logic [ATT_W-1:0] att_q;

    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_rd_en_q, mem_wr_en_q, rd_pend;
    logic [7:0]        mem_wr_data_q, rd_buf;
    logic              cmd_valid_q;
    logic [5:0]        cmd_idx_q;

    logic [5:0]  d_idx;
    logic [31:0] d_arg, d_ext;
    logic [7:0]  d_r1;
    logic        d_has_ext, d_app, d_idle_set, d_idle_clr, d_att_inc, d_att_clr;
    act_t        d_act;

    // ---------------- synchronisers and bit engine ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_s <= 3'b000;
            cs_s   <= 2'b11;
            mosi_s <= 2'b11;
        end else begin
            sclk_s <= {sclk_s[1:0], bus.sclk};
            cs_s   <= {cs_s[0], bus.cs};
            mosi_s <= {mosi_s[0], bus.mosi};
        end
    end

    assign sclk_rise = sclk_s[1] & ~sclk_s[2];
    assign sclk_fall = ~sclk_s[1] & sclk_s[2];
    assign cs_hi     = cs_s[1];
    assign mosi_b    = mosi_s[1];
    assign rx_byte   = {rx_sr, mosi_b};
    assign byte_done = sclk_rise && (bit_cnt == 3'd7) && !cs_hi;

    // The fall right after a byte load must not shift: bit_cnt==0 marks it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= 3'd0;
            rx_sr   <= 7'd0;
            tx_sr   <= 8'hFF;
        end else if (cs_hi) begin
            bit_cnt <= 3'd0;
            tx_sr   <= 8'hFF;
        end else begin
            if (sclk_rise) begin
                rx_sr   <= rx_byte[6:0];
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (byte_done)
                tx_sr <= tx_nxt;
            else if (sclk_fall && bit_cnt != 3'd0)
                tx_sr <= {tx_sr[6:0], 1'b1};
        end
    end

    // ---------------- byte-level FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_HUNT;
            cnt   <= 8'd0;
            off   <= 9'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            off   <= off_nxt;
        end
    end

    // Each decision picks the byte to shift out after the one just completed.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        off_nxt    = off;
        tx_nxt     = 8'hFF;
        frame_done = 1'b0;
        cmd_shift  = 1'b0;
        ext_shift  = 1'b0;
        rd_req     = 1'b0;
        rd_off     = off;
        wr_req     = 1'b0;
        if (cs_hi) begin
            state_nxt = ST_HUNT;
            cnt_nxt   = 8'd0;
            off_nxt   = 9'd0;
        end else if (byte_done) begin
            case (state)
                ST_HUNT: if (rx_byte[7:6] == 2'b01) begin
                    cmd_shift = 1'b1;
                    state_nxt = ST_CMD_RX;
                    cnt_nxt   = 8'd1;
                end
                ST_CMD_RX: if (cnt == 8'd5) begin
                    frame_done = 1'b1;
                    state_nxt  = ST_NCR;
                    cnt_nxt    = 8'd0;
                end else begin
                    cmd_shift = 1'b1;
                    cnt_nxt   = cnt + 8'd1;
                end
                ST_NCR: begin
                    state_nxt = ST_RESP;
                    tx_nxt    = r1_q;
                    cnt_nxt   = 8'd0;
                end
                ST_RESP: if (has_ext_q && cnt != 8'd4) begin
                    tx_nxt    = ext_q[31:24];
                    ext_shift = 1'b1;
                    cnt_nxt   = cnt + 8'd1;
                end else begin
                    cnt_nxt = 8'd0;
                    case (act_q)
                        ACT_RD:  state_nxt = ST_RD_NAC;
                        ACT_WR:  state_nxt = ST_WR_TOKEN;
                        default: state_nxt = ST_HUNT;
                    endcase
                end
                ST_RD_NAC: if (cnt == 8'(NAC_BYTES - 1)) begin
                    state_nxt = ST_RD_TOKEN;
                    tx_nxt    = 8'hFE;
                    cnt_nxt   = 8'd0;
                    off_nxt   = 9'd0;
                    rd_req    = 1'b1;
                    rd_off    = 9'd0;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
                ST_RD_TOKEN: begin
                    state_nxt = ST_RD_DATA;
                    tx_nxt    = rd_buf;
                    rd_req    = 1'b1;
                    rd_off    = 9'd1;
                end
                ST_RD_DATA: if (off == 9'd511) begin
                    state_nxt = ST_RD_CRC;
                    off_nxt   = 9'd0;
                    cnt_nxt   = 8'd0;
                end else begin
                    off_nxt = off + 9'd1;
                    tx_nxt  = rd_buf;
                    rd_req  = (off != 9'd510);
                    rd_off  = off + 9'd2;
                end
                ST_RD_CRC: if (cnt == 8'd1) begin
                    state_nxt = ST_HUNT;
                    cnt_nxt   = 8'd0;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
                ST_WR_TOKEN: if (rx_byte == 8'hFE) begin
                    state_nxt = ST_WR_DATA;
                    off_nxt   = 9'd0;
                end
                ST_WR_DATA: begin
                    wr_req = 1'b1;
                    if (off == 9'd511) begin
                        state_nxt = ST_WR_CRC;
                        off_nxt   = 9'd0;
                        cnt_nxt   = 8'd0;
                    end else begin
                        off_nxt = off + 9'd1;
                    end
                end
                ST_WR_CRC: if (cnt == 8'd1) begin
                    state_nxt = ST_WR_RESP;
                    tx_nxt    = 8'h05;
                    cnt_nxt   = 8'd0;
                end else begin
                    cnt_nxt = cnt + 8'd1;
                end
                ST_WR_RESP: begin
                    state_nxt = ST_WR_BUSY;
                    tx_nxt    = 8'h00;
                    cnt_nxt   = 8'd0;
                end
                ST_WR_BUSY: if (cnt == 8'(BUSY_BYTES - 1)) begin
                    state_nxt = ST_HUNT;
                    cnt_nxt   = 8'd0;
                end else begin
                    tx_nxt  = 8'h00;
                    cnt_nxt = cnt + 8'd1;
                end
                default: state_nxt = ST_HUNT;
            endcase
        end
    end

    // ---------------- command decode ----------------
`ifdef SD_RESP_CRC_CHECK_EN
    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = 7'd0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction
`endif

    assign d_idx = cmd_sr[37:32];
    assign d_arg = cmd_sr[31:0];

    always_comb begin
        d_r1       = {7'd0, card_idle_q} | 8'h04;
        d_ext      = 32'h0;
        d_has_ext  = 1'b0;
        d_act      = ACT_NONE;
        d_app      = 1'b0;
        d_idle_set = 1'b0;
        d_idle_clr = 1'b0;
        d_att_inc  = 1'b0;
        d_att_clr  = 1'b0;
`ifdef SD_RESP_CRC_CHECK_EN
        if (crc7({2'b01, cmd_sr}) != rx_byte[7:1])
            d_r1 = {7'd0, card_idle_q} | 8'h08;
        else
`endif
        if (app_q && d_idx == 6'd41) begin
            if (att_q < ATT_W'(INIT_RETRIES)) begin
                d_r1      = 8'h01;
                d_att_inc = 1'b1;
            end else begin
                d_r1       = 8'h00;
                d_idle_clr = 1'b1;
            end
        end else begin
            case (d_idx)
                6'd0: begin
                    d_r1       = 8'h01;
                    d_idle_set = 1'b1;
                    d_att_clr  = 1'b1;
                end
                6'd8: begin
                    d_r1      = {7'd0, card_idle_q};
                    d_has_ext = 1'b1;
                    d_ext     = {24'h000001, d_arg[7:0]};
                end
                6'd58: begin
                    d_r1      = {7'd0, card_idle_q};
                    d_has_ext = 1'b1;
                    d_ext     = 32'hC0FF_8000;
                end
                6'd55: begin
                    d_r1  = {7'd0, card_idle_q};
                    d_app = 1'b1;
                end
                6'd17, 6'd24: begin
                    if (card_idle_q)
                        d_r1 = 8'h05;
                    else if (d_arg >= 32'(NUM_BLOCKS))
                        d_r1 = 8'h40;
                    else begin
                        d_r1  = 8'h00;
                        d_act = (d_idx == 6'd17) ? ACT_RD : ACT_WR;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_sr        <= '0;
            r1_q          <= 8'hFF;
            ext_q         <= 32'h0;
            has_ext_q     <= 1'b0;
            act_q         <= ACT_NONE;
            blk_q         <= '0;
            card_idle_q   <= 1'b1;
            app_q         <= 1'b0;
            att_q         <= '0;
            mem_addr_q    <= '0;
            mem_rd_en_q   <= 1'b0;
            mem_wr_en_q   <= 1'b0;
            mem_wr_data_q <= 8'h00;
            rd_pend       <= 1'b0;
            rd_buf        <= 8'h00;
            cmd_valid_q   <= 1'b0;
            cmd_idx_q     <= 6'd0;
        end else begin
            if (cmd_shift)
                cmd_sr <= {cmd_sr[29:0], rx_byte};
            if (frame_done) begin
                cmd_idx_q <= d_idx;
                r1_q      <= d_r1;
                ext_q     <= d_ext;
                has_ext_q <= d_has_ext;
                act_q     <= d_act;
                app_q     <= d_app;
                blk_q     <= d_arg[BLK_W-1:0];
                if (d_idle_set)      card_idle_q <= 1'b1;
                else if (d_idle_clr) card_idle_q <= 1'b0;
                if (d_att_clr)       att_q <= '0;
                else if (d_att_inc)  att_q <= att_q + ATT_W'(1);
            end else if (ext_shift) begin
                ext_q <= {ext_q[23:0], 8'h00};
            end
            cmd_valid_q <= frame_done;
            mem_rd_en_q <= rd_req;
            mem_wr_en_q <= wr_req;
            if (rd_req)
                mem_addr_q <= {blk_q, rd_off};
            else if (wr_req) begin
                mem_addr_q    <= {blk_q, off};
                mem_wr_data_q <= rx_byte;
            end
            // RAM answers one clk after the strobe is seen
            rd_pend <= mem_rd_en_q;
            if (rd_pend)
                rd_buf <= bus.mem_rd_data;
        end
    end

    assign bus.miso        = tx_sr[7];
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_rd_en   = mem_rd_en_q;
    assign bus.mem_wr_en   = mem_wr_en_q;
    assign bus.mem_wr_data = mem_wr_data_q;
    assign bus.card_idle   = card_idle_q;
    assign bus.cmd_valid   = cmd_valid_q;
    assign bus.cmd_idx     = cmd_idx_q;
endmodule
